// File: rtl/fp8_pkg.sv
// rtl/fp8_pkg.sv - shared FP8 defaults and issue-stage state type
package fp8_pkg;

  localparam int FP8_WIDTH     = 8;
  localparam int FP8_EXP_WIDTH = 5;
  localparam int FP8_MAN_WIDTH = 2;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fp8_classify.sv
// rtl/fp8_classify.sv - combinational zero/inf/nan decode of a float value
module fp8_classify import fp8_pkg::*; #(
  parameter int EXP_WIDTH = FP8_EXP_WIDTH,
  parameter int MAN_WIDTH = FP8_MAN_WIDTH
) (
  input  logic [EXP_WIDTH+MAN_WIDTH:0] value,
  output logic                         zero,
  output logic                         inf,
  output logic                         nan
);

  logic [EXP_WIDTH-1:0] exp_field;
  logic [MAN_WIDTH-1:0] man_field;
  logic                 exp_ones;
  logic                 man_zero;
  logic                 unused_sign;

  // Sign does not affect the class.
  assign unused_sign = value[EXP_WIDTH+MAN_WIDTH];
  assign exp_field   = value[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
  assign man_field   = value[MAN_WIDTH-1:0];
  assign exp_ones    = &exp_field;
  assign man_zero    = ~|man_field;

  assign nan  = exp_ones & ~man_zero;
  assign inf  = exp_ones &  man_zero;
  assign zero = ~|exp_field & man_zero;

endmodule

// File: rtl/fp8_issue_stage.sv
// rtl/fp8_issue_stage.sv - collects two operands, issues them to an external adder, holds the result
module fp8_issue_stage import fp8_pkg::*; #(
  parameter int WIDTH     = FP8_WIDTH,
  parameter int EXP_WIDTH = FP8_EXP_WIDTH,
  parameter int MAN_WIDTH = FP8_MAN_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sub,
  output logic             in_ready,
  input  logic             in_clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_sub,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_zero,
  output logic             res_inf,
  output logic             res_nan,
  output logic [7:0]       ops_done
);

  state_t state, state_nxt;
  logic   cls_zero, cls_inf, cls_nan;

  fp8_classify #(
    .EXP_WIDTH(EXP_WIDTH),
    .MAN_WIDTH(MAN_WIDTH)
  ) u_classify (
    .value(sum_in),
    .zero (cls_zero),
    .inf  (cls_inf),
    .nan  (cls_nan)
  );

  assign in_ready = (state == LOAD_A) || (state == LOAD_B);

  // Abort overrides every transition, including a coincident transfer or handshake.
  always_comb begin
    state_nxt = state;
    if (in_clear) begin
      state_nxt = LOAD_A;
    end else begin
      case (state)
        LOAD_A:  if (in_valid) state_nxt = LOAD_B;
        LOAD_B:  if (in_valid) state_nxt = EXEC;
        EXEC:    state_nxt = DONE;
        DONE:    if (res_ready) state_nxt = LOAD_A;
        default: state_nxt = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      op_a      <= '0;
      op_b      <= '0;
      op_sub    <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
      res_zero  <= 1'b0;
      res_inf   <= 1'b0;
      res_nan   <= 1'b0;
      ops_done  <= 8'd0;
    end else begin
      state <= state_nxt;
      if (in_clear) begin
        res_valid <= 1'b0;
        res_zero  <= 1'b0;
        res_inf   <= 1'b0;
        res_nan   <= 1'b0;
      end else begin
        case (state)
          LOAD_A: if (in_valid) op_a <= in_data;
          LOAD_B: if (in_valid) begin
            op_b   <= in_data;
            op_sub <= in_sub;
          end
          EXEC: begin
            res_data  <= sum_in;
            res_valid <= 1'b1;
            res_zero  <= cls_zero;
            res_inf   <= cls_inf;
            res_nan   <= cls_nan;
          end
          DONE: if (res_ready) begin
            res_valid <= 1'b0;
            ops_done  <= ops_done + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
